// File: rtl/sid_stream_decoder.sv
// sid_stream_decoder: host byte stream to multi-SID register writes.
// Decoded writes and host-timed delays are queued in a FIFO and released
// one per 1 MHz tick (i_clk_en), so playback timing follows the stream.
// Optional feature macro: SID_STREAM_DELAY_EN (DELAY commands honoured).
// Ports:
//   clk, rst            24 MHz clock, synchronous active-high reset
//   i_clk_en            1 MHz tick, one clk wide
//   i_data/i_valid      stream byte in; o_ready accepts it
//   o_addr/o_data/o_we  registered SID write, o_we one-hot per chip
//   o_level             FIFO occupancy
//   o_busy              FIFO non-empty or delay running
module sid_stream_decoder #(
    parameter int NUM_SID    = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clk_en,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [4:0]                    o_addr,
    output logic [7:0]                    o_data,
    output logic [NUM_SID-1:0]            o_we,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    // Entry: [15:13] bank, [12:8] addr, [7:0] data; [16] marks a DELAY
    // whose count sits in [4:0].
`ifdef SID_STREAM_DELAY_EN
    localparam int EW = 17;
`else
    localparam int EW = 16;
`endif

    logic [EW-1:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [2:0]         bank_q, bank_d;
    logic [4:0]         addr_q, addr_d;
    logic [7:0]         data_q, data_d;
    logic [4:0]         out_addr_q, out_addr_d;
    logic [7:0]         out_data_q, out_data_d;
    logic [NUM_SID-1:0] we_q, we_d;
    logic               busy_q, busy_d;
    logic               accept, push, pop, wr_pop;
    logic [EW-1:0]      push_entry, head;
`ifdef SID_STREAM_DELAY_EN
    logic [4:0]         dly_q, dly_d;
`endif

    // Ready is gated for every byte type, so a full FIFO stalls the stream.
    assign o_ready = !rst && (level_q != LW'(FIFO_DEPTH));
    assign accept  = i_valid && o_ready;
    assign head    = mem_q[rd_ptr_q];

    // Byte decode and latch update.
    always_comb begin
        bank_d     = bank_q;
        addr_d     = addr_q;
        data_d     = data_q;
        push       = 1'b0;
        push_entry = '0;
        if (accept) begin
            if (i_data[7]) begin
                addr_d = i_data[6:2];
                data_d = {i_data[1:0], data_q[5:0]};
            end else if (!i_data[6]) begin
                data_d = {data_q[7:6], i_data[5:0]};
                push   = 1'b1;
                push_entry[15:0] = {bank_q, addr_q, data_d};
            end else if (i_data[5]) begin
`ifdef SID_STREAM_DELAY_EN
                push            = 1'b1;
                push_entry[16]  = 1'b1;
                push_entry[4:0] = i_data[4:0];
`else
                push = 1'b0;
`endif
            end else if (i_data[4:3] == 2'b00) begin
                if (int'(i_data[2:0]) < NUM_SID) begin
                    bank_d = i_data[2:0];
                end
            end
        end
    end

    // Pop engine. Pop decisions use the registered level, so an entry
    // pushed on this edge can never be popped on the same edge.
    always_comb begin
        pop        = 1'b0;
        wr_pop     = 1'b0;
        we_d       = '0;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
`ifdef SID_STREAM_DELAY_EN
        dly_d = dly_q;
        if (i_clk_en) begin
            if (dly_q != 5'd0) begin
                dly_d = dly_q - 5'd1;
            end else if (level_q != '0) begin
                pop = 1'b1;
                if (head[16]) begin
                    dly_d = head[4:0];
                end else begin
                    wr_pop = 1'b1;
                end
            end
        end
`else
        if (i_clk_en && (level_q != '0)) begin
            pop    = 1'b1;
            wr_pop = 1'b1;
        end
`endif
        if (wr_pop) begin
            out_addr_d = head[12:8];
            out_data_d = head[7:0];
            for (int i = 0; i < NUM_SID; i++) begin
                if (head[15:13] == 3'(i)) begin
                    we_d[i] = 1'b1;
                end
            end
        end
    end

    // Pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        busy_d = (level_d != '0);
`ifdef SID_STREAM_DELAY_EN
        if (dly_d != 5'd0) begin
            busy_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            bank_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            we_q       <= '0;
            busy_q     <= 1'b0;
`ifdef SID_STREAM_DELAY_EN
            dly_q      <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            bank_q     <= bank_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
`ifdef SID_STREAM_DELAY_EN
            dly_q      <= dly_d;
`endif
        end
    end

    // Storage needs no reset; push is blocked while rst is high.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign o_addr  = out_addr_q;
    assign o_data  = out_data_q;
    assign o_we    = we_q;
    assign o_level = level_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_sid_stream_decoder.sv
// tb_sid_stream_decoder: directed checks for sid_stream_decoder.
// Two instances: default depth (a_*) and FIFO_DEPTH=4 (b_*).
module tb_sid_stream_decoder;

`ifdef SID_STREAM_DELAY_EN
    localparam int GAP       = 5;
    localparam int DLY_LEVEL = 3;
    localparam int MID_LEVEL = 3;
`else
    localparam int GAP       = 1;
    localparam int DLY_LEVEL = 2;
    localparam int MID_LEVEL = 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       a_en = 1'b0, a_valid = 1'b0;
    logic [7:0] a_din = 8'h00;
    logic       a_ready, a_busy;
    logic [4:0] a_addr, a_level;
    logic [7:0] a_dout;
    logic [1:0] a_we;

    logic       b_en = 1'b0, b_valid = 1'b0;
    logic [7:0] b_din = 8'h00;
    logic       b_ready, b_busy;
    logic [4:0] b_addr;
    logic [2:0] b_level;
    logic [7:0] b_dout;
    logic [1:0] b_we;

    int checks = 0;
    int failures = 0;

    sid_stream_decoder u_a (
        .clk(clk), .rst(rst), .i_clk_en(a_en),
        .i_data(a_din), .i_valid(a_valid), .o_ready(a_ready),
        .o_addr(a_addr), .o_data(a_dout), .o_we(a_we),
        .o_level(a_level), .o_busy(a_busy)
    );

    sid_stream_decoder #(.NUM_SID(2), .FIFO_DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .i_clk_en(b_en),
        .i_data(b_din), .i_valid(b_valid), .o_ready(b_ready),
        .o_addr(b_addr), .o_data(b_dout), .o_we(b_we),
        .o_level(b_level), .o_busy(b_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] b);
        a_din = b;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
    endtask

    task automatic tick_a();
        a_en = 1'b1;
        step();
        a_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready got=%b/%b want=0/0", a_ready, b_ready);
        end
        checks++;
        if (a_level !== 5'd0 || b_level !== 3'd0) begin
            failures++;
            $display("FAIL rst_level got=%0d/%0d want=0", a_level, b_level);
        end
        checks++;
        if (a_busy !== 1'b0 || a_we !== 2'b00) begin
            failures++;
            $display("FAIL rst_busy_we got=%b/%b want=0/00", a_busy, a_we);
        end
        checks++;
        if (a_addr !== 5'd0 || a_dout !== 8'd0) begin
            failures++;
            $display("FAIL rst_addr_data got=%h/%h want=0/0", a_addr, a_dout);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_release_ready got=%b/%b want=1/1", a_ready, b_ready);
        end
        step();
    endtask

    task automatic test_basic();
        send_a(8'h94);
        send_a(8'h2A);
        checks++;
        if (a_level !== 5'd1 || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_queued got=%0d/%b want=1/1", a_level, a_busy);
        end
        checks++;
        if (a_we !== 2'b00) begin
            failures++;
            $display("FAIL basic_no_early_we got=%b want=00", a_we);
        end
        tick_a();
        checks++;
        if (a_we !== 2'b01 || a_addr !== 5'd5 || a_dout !== 8'h2A) begin
            failures++;
            $display("FAIL basic_write got=%b/%h/%h want=01/05/2a", a_we, a_addr, a_dout);
        end
        checks++;
        if (a_level !== 5'd0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_drained got=%0d/%b want=0/0", a_level, a_busy);
        end
        step();
        checks++;
        if (a_we !== 2'b00 || a_addr !== 5'd5 || a_dout !== 8'h2A) begin
            failures++;
            $display("FAIL basic_hold got=%b/%h/%h want=00/05/2a", a_we, a_addr, a_dout);
        end
    endtask

    task automatic test_bank();
        send_a(8'h41);
        send_a(8'hE0);
        send_a(8'h05);
        tick_a();
        checks++;
        if (a_we !== 2'b10 || a_addr !== 5'h18 || a_dout !== 8'h05) begin
            failures++;
            $display("FAIL bank1_write got=%b/%h/%h want=10/18/05", a_we, a_addr, a_dout);
        end
        send_a(8'h47);
        send_a(8'h55);
        checks++;
        if (a_level !== 5'd0) begin
            failures++;
            $display("FAIL bank_ignored_push got=%0d want=0", a_level);
        end
        send_a(8'h3F);
        tick_a();
        checks++;
        if (a_we !== 2'b10 || a_addr !== 5'h18 || a_dout !== 8'h3F) begin
            failures++;
            $display("FAIL bank7_ignored got=%b/%h/%h want=10/18/3f", a_we, a_addr, a_dout);
        end
    endtask

    task automatic test_delay();
        int nw;
        int t0, t1;
        logic [7:0] d0, d1;
        nw = 0; t0 = -1; t1 = -1; d0 = 8'h00; d1 = 8'h00;
        send_a(8'h80);
        send_a(8'h01);
        send_a(8'h63);
        send_a(8'h02);
        checks++;
        if (a_level !== 5'(DLY_LEVEL)) begin
            failures++;
            $display("FAIL delay_level got=%0d want=%0d", a_level, DLY_LEVEL);
        end
        for (int t = 0; t < 10; t++) begin
            tick_a();
            if (a_we !== 2'b00) begin
                if (nw == 0) begin t0 = t; d0 = a_dout; end
                else begin t1 = t; d1 = a_dout; end
                nw++;
            end
        end
        checks++;
        if (nw != 2) begin
            failures++;
            $display("FAIL delay_count got=%0d want=2", nw);
        end
        checks++;
        if (t0 != 0 || d0 !== 8'h01) begin
            failures++;
            $display("FAIL delay_first got=t%0d/%h want=t0/01", t0, d0);
        end
        checks++;
        if (t1 != GAP || d1 !== 8'h02) begin
            failures++;
            $display("FAIL delay_second got=t%0d/%h want=t%0d/02", t1, d1, GAP);
        end
        checks++;
        if (a_level !== 5'd0 || a_busy !== 1'b0 || a_addr !== 5'd0) begin
            failures++;
            $display("FAIL delay_idle got=%0d/%b/%h want=0/0/00", a_level, a_busy, a_addr);
        end
    endtask

    task automatic test_fifo_full();
        int sent, got;
        logic acc;
        logic [7:0] seen [6];
        for (int i = 0; i < 6; i++) seen[i] = 8'h00;
        b_en = 1'b0;
        b_din = 8'h88;
        b_valid = 1'b1;
        step();
        sent = 0;
        b_din = 8'h11;
        for (int c = 0; c < 6; c++) begin
            acc = b_ready;
            step();
            if (acc) begin
                sent++;
                b_din = 8'h11 + 8'(sent);
            end
        end
        checks++;
        if (sent != 4) begin
            failures++;
            $display("FAIL full_accepted got=%0d want=4", sent);
        end
        checks++;
        if (b_ready !== 1'b0 || b_level !== 3'd4) begin
            failures++;
            $display("FAIL full_stall got=%b/%0d want=0/4", b_ready, b_level);
        end
        got = 0;
        b_en = 1'b1;
        for (int c = 0; c < 40 && (got < 6 || b_valid); c++) begin
            acc = b_valid && b_ready;
            step();
            if (b_we !== 2'b00) begin
                if (got < 6) seen[got] = b_dout;
                got++;
            end
            if (acc) begin
                sent++;
                if (sent < 6) b_din = 8'h11 + 8'(sent);
                else b_valid = 1'b0;
            end
        end
        b_en = 1'b0;
        b_valid = 1'b0;
        checks++;
        if (sent != 6 || got != 6) begin
            failures++;
            $display("FAIL full_totals got=%0d/%0d want=6/6", sent, got);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (seen[i] !== 8'h11 + 8'(i)) begin
                failures++;
                $display("FAIL full_order[%0d] got=%h want=%h", i, seen[i], 8'h11 + 8'(i));
            end
        end
        checks++;
        if (b_level !== 3'd0 || b_addr !== 5'd2) begin
            failures++;
            $display("FAIL full_end got=%0d/%h want=0/02", b_level, b_addr);
        end
    endtask

    task automatic test_push_pop();
        send_a(8'h40);
        send_a(8'h84);
        send_a(8'h21);
        send_a(8'h22);
        checks++;
        if (a_level !== 5'd2) begin
            failures++;
            $display("FAIL pp_pre got=%0d want=2", a_level);
        end
        a_din = 8'h23;
        a_valid = 1'b1;
        a_en = 1'b1;
        step();
        a_valid = 1'b0;
        a_en = 1'b0;
        checks++;
        if (a_level !== 5'd2 || a_we !== 2'b01 || a_dout !== 8'h21 || a_addr !== 5'd1) begin
            failures++;
            $display("FAIL pp_same_edge got=%0d/%b/%h/%h want=2/01/21/01",
                     a_level, a_we, a_dout, a_addr);
        end
        tick_a();
        checks++;
        if (a_we !== 2'b01 || a_dout !== 8'h22 || a_level !== 5'd1) begin
            failures++;
            $display("FAIL pp_second got=%b/%h/%0d want=01/22/1", a_we, a_dout, a_level);
        end
        tick_a();
        checks++;
        if (a_we !== 2'b01 || a_dout !== 8'h23 || a_level !== 5'd0) begin
            failures++;
            $display("FAIL pp_third got=%b/%h/%0d want=01/23/0", a_we, a_dout, a_level);
        end
        tick_a();
        checks++;
        if (a_we !== 2'b00 || a_dout !== 8'h23) begin
            failures++;
            $display("FAIL pp_no_dup got=%b/%h want=00/23", a_we, a_dout);
        end
    endtask

    task automatic test_reset_mid();
        int nw;
        send_a(8'h41);
        send_a(8'hBF);
        send_a(8'h6A);
        send_a(8'h01);
        send_a(8'h02);
        send_a(8'h03);
        tick_a();
        checks++;
        if (a_level !== 5'(MID_LEVEL) || a_busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre got=%0d/%b want=%0d/1", a_level, a_busy, MID_LEVEL);
        end
        rst = 1'b1;
        a_en = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_ready got=%b want=0", a_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_en = 1'b0;
        checks++;
        if (a_we !== 2'b00) begin
            failures++;
            $display("FAIL mid_strobe_suppressed got=%b want=00", a_we);
        end
        checks++;
        if (a_level !== 5'd0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_cleared got=%0d/%b want=0/0", a_level, a_busy);
        end
        nw = 0;
        for (int t = 0; t < 12; t++) begin
            tick_a();
            if (a_we !== 2'b00) nw++;
        end
        checks++;
        if (nw != 0) begin
            failures++;
            $display("FAIL mid_no_writes got=%0d want=0", nw);
        end
        send_a(8'h05);
        tick_a();
        checks++;
        if (a_we !== 2'b01 || a_addr !== 5'd0 || a_dout !== 8'h05) begin
            failures++;
            $display("FAIL mid_latches got=%b/%h/%h want=01/00/05", a_we, a_addr, a_dout);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bank();
        test_delay();
        test_fifo_full();
        test_push_pop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sid_stream_decoder.md
# sid_stream_decoder

Parametrised successor to the single-SID USB byte decoder. It turns the host byte stream into SID register writes for up to `NUM_SID` chips. Decoded writes and host-timed delays go through a FIFO and are released only on the 1 MHz SID clock enable, so playback timing is set by the stream rather than by USB arrival jitter. It sits between the USB ACM `out_*` stream and the `sid` instances' `iWE`/`iAddr`/`iDataW` inputs.

## Interface
Parameters:
- `NUM_SID`, default 2: number of SID targets, 1..8.
- `FIFO_DEPTH`, default 16: command FIFO entries, power of two, 4..256.

Ports:
- `clk` in 1: system clock, 24 MHz. One clock domain; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `i_clk_en` in 1: 1 MHz SID clock enable, one `clk` wide.
- `i_data` in 8: stream byte.
- `i_valid` in 1: `i_data` valid.
- `o_ready` out 1: byte accepted on an edge where `i_valid && o_ready`.
- `o_addr` out 5: SID register address.
- `o_data` out 8: SID write data.
- `o_we` out NUM_SID: one-hot write strobe, one `clk` wide.
- `o_level` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `o_busy` out 1: FIFO non-empty or delay counter non-zero.

## Operation
Byte formats:
- `1AAA AADD`: latch address `A`; latch data[7:6]=`DD`. No FIFO push.
- `00DD DDDD`: set data[5:0]=`D`. Push WRITE{bank, addr, data} into the FIFO.
- `0100 0BBB`: set bank=`B`. Ignored if `B >= NUM_SID`. No push.
- `011D DDDD`: push DELAY{D}.
- `0100 1xxx` and `0101 xxxx`: reserved. Accepted and discarded.

Latches:
- Address, data and bank latches persist across writes. Repeated LSB bytes re-write the same address with new low bits.

Push rule:
- Every accepted byte is consumed. `o_ready = !rst && (o_level != FIFO_DEPTH)`. It is gated for all byte types, including non-pushing ones.

Pop engine (`dly_cnt`, width 5):
- A pop is evaluated only in cycles where `i_clk_en=1`.
- If `dly_cnt != 0`: decrement `dly_cnt`. No pop.
- Else, if the FIFO is non-empty, pop the head:
  - WRITE: register `o_addr`/`o_data`, set `o_we[bank]`.
  - DELAY{D}: load `dly_cnt` with `D`.
- A DELAY{D} therefore consumes D+1 ticks, including its own. A WRITE consumes 1 tick.
- At most one SID write per tick, across all banks.

Simultaneous push and pop:
- Both take effect on the same edge.
- `o_level` does not change.
- The pushed entry is never popped on the same edge, even when the FIFO was empty.

## Timing
Reset values (on the edge `rst=1` is sampled):
- FIFO empty, `o_level=0`, `dly_cnt=0`.
- Latches: bank=0, addr=0, data=0.
- `o_we=0`, `o_addr=0`, `o_data=0`, `o_busy=0`.
- `o_ready=0` while `rst=1`.

Reset mid-operation:
- Pending FIFO entries and any running delay are discarded.
- A strobe due on the next edge is suppressed.

Latency and outputs:
- LSB byte accepted at edge k with the engine idle: the entry is visible from k+1. `o_we` rises on the edge ending the first `i_clk_en` cycle at or after k+1, and is high for exactly one `clk`.
- `o_addr`/`o_data` change only with a WRITE pop. They hold after the strobe.
- `o_level` and `o_busy` are registered and update on the push/pop edge.
- Pointers wrap modulo `FIFO_DEPTH`. Occupancy uses a separate counter, so full and empty are unambiguous.

## Configuration
- `SID_STREAM_DELAY_EN` defined:
  - DELAY commands are pushed and honoured as above.
- Not defined:
  - `011D DDDD` bytes are accepted and discarded.
  - `dly_cnt` is removed.
  - Every tick with a non-empty FIFO pops a WRITE.

## Test plan
- Bytes 0x94, 0x2A with `NUM_SID=2`: single `o_we=2'b01` pulse on the next tick, addr=5, data=0x2A. `o_level` returns to 0.
- Bytes 0x41, 0xE0, 0x05: write lands on bank 1 (`o_we=2'b10`), addr=0x18, data=0x05. A following 0x47 is ignored, so the next LSB still targets bank 1.
- Bytes 0x80, 0x01, 0x63, 0x02 (DELAY_EN defined): writes data 0x01 and 0x02 to addr 0 land on ticks t and t+5. Without the macro they land on t and t+1.
- `FIFO_DEPTH=4`, `i_clk_en` held 0, 6 LSB bytes offered: first four accepted, then `o_ready=0` with `o_level=4`. After enabling ticks: writes pop one per tick in order, and the remaining two bytes are accepted as slots free.
- Push and pop on the same edge at `o_level=2`: `o_level` stays 2 and no entry is lost or duplicated.
- `rst` asserted during a 10-tick delay with 3 entries queued: no further `o_we`. After release `o_level=0`, `o_busy=0`, and bank/addr/data are 0.
